// File: rtl/el_video_capture.sv
// el_video_capture: oversampling receiver for the EL panel video interface, emitting a packed frame-buffer write stream
module el_video_capture #(
    parameter int H_ACTIVE   = 512,
    parameter int V_ACTIVE   = 256,
    parameter int ADDR_W     = 14,
    parameter int VID_INVERT = 1
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              capture_en,
    input  logic              el_vs,
    input  logic              el_hs,
    input  logic              el_vclk,
    input  logic              el_vid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              line_err,
    output logic              busy
);
    localparam int XW = $clog2(H_ACTIVE) + 1;
    localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LINE = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
    localparam logic [LW-1:0] L_LAST = LW'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] H_BYTES = ADDR_W'(H_ACTIVE / 8);

    logic [3:0]        meta_q, sync_q;
    logic [1:0]        hist_q;
    logic [1:0]        state_q, state_d;
    logic [LW-1:0]     line_q, line_d;
    logic [XW-1:0]     x_q, x_d, xc;
    logic              ovr_q, ovr_d;
    logic [7:0]        byte_q, byte_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;
    logic              vs_s, pix, hs_rise, hs_fall, vclk_fall, start, samp;

    // Two-flop synchronizer on {vs, hs, vclk, vid}, plus history of hs and vclk for edge detection
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            meta_q <= {el_vs, el_hs, el_vclk, el_vid};
            sync_q <= meta_q;
            hist_q <= sync_q[2:1];
        end
    end

    assign vs_s      = sync_q[3];
    assign pix       = sync_q[0] ^ (VID_INVERT != 0);
    assign hs_rise   = sync_q[2] & ~hist_q[1];
    assign hs_fall   = ~sync_q[2] & hist_q[1];
    assign vclk_fall = ~sync_q[1] & hist_q[0];

    // Line/frame sequencing, pixel packing and write generation
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        x_d          = x_q;
        ovr_d        = ovr_q;
        byte_d       = byte_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        line_err_d   = 1'b0;
        start        = 1'b0;
        samp         = 1'b0;
        if (!capture_en) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            start = hs_rise & vs_s;
        end else if (state_q == GAP) begin
            start      = hs_rise;
            line_err_d = hs_rise & vs_s;
        end else if (hs_fall) begin
            line_err_d   = (x_q != X_END) || ovr_q;
            x_d          = '0;
            ovr_d        = 1'b0;
            frame_done_d = (line_q == L_LAST);
            state_d      = (line_q == L_LAST) ? IDLE : GAP;
        end else begin
            samp = vclk_fall;
        end
        if (start) begin
            state_d = LINE;
            line_d  = (state_q == GAP && !vs_s) ? line_q + 1'b1 : '0;
            x_d     = '0;
            ovr_d   = 1'b0;
            samp    = vclk_fall;
        end
        xc = start ? '0 : x_q;
        if (samp && xc < X_END) begin
            byte_d[xc[2:0]] = pix;
            x_d             = xc + 1'b1;
            wr_en_d         = &xc[2:0];
            if (&xc[2:0]) begin
                wr_data_d = byte_d;
                wr_addr_d = ADDR_W'(line_d) * H_BYTES + ADDR_W'(xc >> 3);
            end
        end else if (samp) begin
            ovr_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            line_q       <= '0;
            x_q          <= '0;
            ovr_q        <= 1'b0;
            byte_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            x_q          <= x_d;
            ovr_q        <= ovr_d;
            byte_q       <= byte_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_el_video_capture.sv
// tb_el_video_capture: directed checks of the EL video receiver on a reduced 16x4 panel geometry
module tb_el_video_capture;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int AW = 3;

    logic          clk_50 = 1'b0;
    logic          rst = 1'b1;
    logic          capture_en = 1'b1;
    logic          el_vs = 1'b0;
    logic          el_hs = 1'b0;
    logic          el_vclk = 1'b0;
    logic          el_vid = 1'b1;
    logic          wr_en, frame_done, line_err, busy;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    int checks = 0;
    int errors = 0;
    int wr_n = 0;
    int fd_n = 0;
    int le_n = 0;
    int b_wr, b_fd, b_le;
    int log_addr [128];
    int log_data [128];

    always #10 clk_50 = ~clk_50;

    el_video_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .VID_INVERT(1)) dut (
        .clk_50(clk_50), .rst(rst), .capture_en(capture_en),
        .el_vs(el_vs), .el_hs(el_hs), .el_vclk(el_vclk), .el_vid(el_vid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .line_err(line_err), .busy(busy)
    );

    // Logs every write and counts pulses, sampled on the falling edge
    always @(negedge clk_50) begin
        if (wr_en) begin
            if (wr_n < 128) begin
                log_addr[wr_n] <= int'(wr_addr);
                log_data[wr_n] <= int'(wr_data);
            end
            wr_n <= wr_n + 1;
        end
        if (frame_done) fd_n <= fd_n + 1;
        if (line_err) le_n <= le_n + 1;
    end

    function automatic logic pix(int x, int y);
        return 1'(((x * 7 + y * 3) >> 2) & 1);
    endfunction

    function automatic int exp_byte(int y, int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = pix(b * 8 + i, y);
        return int'(r);
    endfunction

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_line_err"}, int'(line_err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic mark();
        b_wr = wr_n;
        b_fd = fd_n;
        b_le = le_n;
    endtask

    // One line of n pixels; coin aligns the first vclk fall with hs rise and adds an extra fall on hs fall
    task automatic send_line(int y, int n, bit vs, bit coin, int abort_at, int rst_at);
        el_vs = vs;
        if (coin) begin
            el_vid  = ~pix(0, y);
            el_vclk = 1'b1;
            tick(2);
            el_hs   = 1'b1;
            el_vclk = 1'b0;
            tick(2);
        end else begin
            el_hs = 1'b1;
        end
        for (int x = coin ? 1 : 0; x < n; x++) begin
            if (x == abort_at) capture_en = 1'b0;
            if (x == rst_at) begin
                rst = 1'b1;
                #1;
                chk_zero("rst_mid");
                tick(3);
                rst = 1'b0;
            end
            el_vid  = ~pix(x, y);
            el_vclk = 1'b1;
            tick(2);
            el_vclk = 1'b0;
            tick(2);
        end
        if (coin) begin
            el_vid  = ~pix(n, y);
            el_vclk = 1'b1;
            tick(2);
            el_vclk = 1'b0;
        end
        el_hs = 1'b0;
        tick(8);
        el_vs      = 1'b0;
        capture_en = 1'b1;
    endtask

    task automatic frame(int sl, int sn, bit coin, int ab, int rs);
        for (int y = 0; y < V; y++)
            send_line(y, (y == sl) ? sn : H, y == 0, coin, (y == sl) ? ab : -1, (y == sl) ? rs : -1);
    endtask

    // Expected stream: lines below ylim, line sl carrying sn pixels, all others H
    task automatic verify(string tag, int sl, int sn, int ylim, int efd, int ele);
        int k = 0;
        for (int y = 0; y < ylim; y++) begin
            int n = (y == sl) ? sn : H;
            for (int b = 0; b < ((n > H) ? H : n) / 8; b++) begin
                if (b_wr + k < wr_n && b_wr + k < 128) begin
                    chk({tag, "_addr"}, log_addr[b_wr + k], y * (H / 8) + b);
                    chk({tag, "_data"}, log_data[b_wr + k], exp_byte(y, b));
                end
                k++;
            end
        end
        chk({tag, "_writes"}, wr_n - b_wr, k);
        chk({tag, "_frame_done"}, fd_n - b_fd, efd);
        chk({tag, "_line_err"}, le_n - b_le, ele);
    endtask

    initial begin
        tick(3);
        chk_zero("reset");
        rst = 1'b0;
        tick(4);
        mark();
        send_line(0, H, 1'b1, 1'b0, -1, -1);
        chk("busy_mid_frame", int'(busy), 1);
        for (int y = 1; y < V; y++) send_line(y, H, 1'b0, 1'b0, -1, -1);
        chk("busy_after_frame", int'(busy), 0);
        verify("full", -1, 0, V, 1, 0);
        mark();
        frame(1, 12, 1'b0, -1, -1);
        verify("short", 1, 12, V, 1, 1);
        mark();
        frame(2, 20, 1'b0, -1, -1);
        verify("long", 2, 20, V, 1, 1);
        mark();
        frame(1, H, 1'b0, 3, -1);
        verify("abort", 1, 3, 2, 0, 0);
        mark();
        frame(-1, 0, 1'b0, -1, -1);
        verify("after_abort", -1, 0, V, 1, 0);
        mark();
        frame(1, H, 1'b0, -1, 12);
        verify("rst_frame", 1, 12, 2, 0, 0);
        mark();
        frame(-1, 0, 1'b0, -1, -1);
        verify("after_rst", -1, 0, V, 1, 0);
        mark();
        frame(-1, 0, 1'b1, -1, -1);
        verify("coincide", -1, 0, V, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
